// File: rtl/ddr3_init_seq.sv
// ddr3_init_seq
// DDR3 power-up / initialization sequencer. Walks the SDRAM through reset
// hold, CKE wait, tXPR, the MR2/MR3/MR1/MR0 loads, ZQCL and tZQINIT. It then
// raises init_done and leaves NOPs on the bus. A request while done re-runs
// the whole bring-up.
//
// Ports
//   ck         : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   init_req   : re-initialization request, honoured only while init_done=1
//   mem_rst_n  : DDR3 RESET#
//   mem_cke    : DDR3 CKE
//   mem_cs_n   : per-rank chip selects (all ranks are commanded together)
//   mem_ras_n, mem_cas_n, mem_we_n : command pins
//   mem_ba     : bank address (mode register index during MRS)
//   mem_addr   : address (mode register value during MRS, A10=1 for ZQCL)
//   mem_odt    : per-rank ODT, held low throughout initialization
//   init_done  : sequence complete, bus released to the controller
module ddr3_init_seq #(
  parameter int                   ADDR_BITS = 14,
  parameter int                   BA_BITS   = 3,
  parameter int                   RANKS     = 1,
  parameter int                   T_RESET   = 213208,
  parameter int                   T_CKE     = 533049,
  parameter int                   T_XPR     = 128,
  parameter int                   T_MRD     = 4,
  parameter int                   T_MOD     = 12,
  parameter int                   T_ZQINIT  = 512,
  parameter logic [ADDR_BITS-1:0] MR0       = '0,
  parameter logic [ADDR_BITS-1:0] MR1       = '0,
  parameter logic [ADDR_BITS-1:0] MR2       = '0,
  parameter logic [ADDR_BITS-1:0] MR3       = '0
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic                 init_req,
  output logic                 mem_rst_n,
  output logic                 mem_cke,
  output logic [RANKS-1:0]     mem_cs_n,
  output logic                 mem_ras_n,
  output logic                 mem_cas_n,
  output logic                 mem_we_n,
  output logic [BA_BITS-1:0]   mem_ba,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [RANKS-1:0]     mem_odt,
  output logic                 init_done
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_RESET, T_CKE), max2(T_XPR, T_MRD)),
                              max2(T_MOD, T_ZQINIT));
  localparam int CNT_W = $clog2(T_MAX + 1);

  // The counter holds "edges remaining minus one", so an interval of 1 expires
  // on the very next edge and the transition edge is exactly T cycles after entry.
  localparam logic [CNT_W-1:0] LD_RESET  = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0] LD_CKE    = CNT_W'(T_CKE - 1);
  localparam logic [CNT_W-1:0] LD_XPR    = CNT_W'(T_XPR - 1);
  localparam logic [CNT_W-1:0] LD_MRD    = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] LD_MOD    = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] LD_ZQINIT = CNT_W'(T_ZQINIT - 1);

  typedef enum logic [2:0] {
    ST_RESET_HOLD, ST_CKE_WAIT, ST_XPR, ST_MRS, ST_MOD, ST_ZQ, ST_DONE
  } state_t;

  typedef enum logic [1:0] {CMD_NOP, CMD_MRS, CMD_ZQCL} cmd_t;

  typedef struct packed {
    logic                 rst_n;
    logic                 cke;
    logic                 cs_n;
    logic                 ras_n;
    logic                 cas_n;
    logic                 we_n;
    logic [BA_BITS-1:0]   ba;
    logic [ADDR_BITS-1:0] addr;
    logic                 done;
  } pins_t;

  localparam pins_t PINS_RESET = '{rst_n: 1'b0, cke: 1'b0, cs_n: 1'b1,
                                   ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
                                   ba: '0, addr: '0, done: 1'b0};
  localparam pins_t PINS_NOP   = '{rst_n: 1'b1, cke: 1'b1, cs_n: 1'b0,
                                   ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
                                   ba: '0, addr: '0, done: 1'b0};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       step_q, step_d;   // 0..3 -> MR2, MR3, MR1, MR0
  pins_t            pins_q, pins_d;
  cmd_t             cmd;
  logic             expire;

  assign expire = (cnt_q == '0);

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cmd     = CMD_NOP;
    cnt_d   = expire ? cnt_q : cnt_q - CNT_W'(1);

    unique case (state_q)
      ST_RESET_HOLD: if (expire) begin
        state_d = ST_CKE_WAIT;
        cnt_d   = LD_CKE;
      end
      ST_CKE_WAIT: if (expire) begin
        state_d = ST_XPR;
        cnt_d   = LD_XPR;
      end
      ST_XPR: if (expire) begin
        state_d = ST_MRS;
        step_d  = 2'd0;
        cnt_d   = LD_MRD;
        cmd     = CMD_MRS;
      end
      // MR0 is issued on the edge that enters MOD, because tMOD is measured
      // from the MR0 edge rather than from the end of a tMRD window.
      ST_MRS: if (expire) begin
        step_d = step_q + 2'd1;
        cmd    = CMD_MRS;
        if (step_q == 2'd2) begin
          state_d = ST_MOD;
          cnt_d   = LD_MOD;
        end else begin
          cnt_d   = LD_MRD;
        end
      end
      ST_MOD: if (expire) begin
        state_d = ST_ZQ;
        cnt_d   = LD_ZQINIT;
        cmd     = CMD_ZQCL;
      end
      ST_ZQ: if (expire) begin
        state_d = ST_DONE;
      end
      ST_DONE: if (init_req) begin
        state_d = ST_RESET_HOLD;
        cnt_d   = LD_RESET;
      end
      default: begin
        state_d = ST_RESET_HOLD;
        cnt_d   = LD_RESET;
      end
    endcase

    // Pin levels follow the state being entered; a command overrides the NOP
    // for the single entry edge only.
    pins_d = PINS_NOP;
    unique case (state_d)
      ST_RESET_HOLD: pins_d = PINS_RESET;
      ST_CKE_WAIT: begin
        pins_d       = PINS_RESET;
        pins_d.rst_n = 1'b1;
      end
      ST_DONE:       pins_d.done = 1'b1;
      default:       ;
    endcase

    unique case (cmd)
      CMD_MRS: begin
        pins_d.ras_n = 1'b0;
        pins_d.cas_n = 1'b0;
        pins_d.we_n  = 1'b0;
        unique case (step_d)
          2'd0:    begin pins_d.ba = BA_BITS'(2); pins_d.addr = MR2; end
          2'd1:    begin pins_d.ba = BA_BITS'(3); pins_d.addr = MR3; end
          2'd2:    begin pins_d.ba = BA_BITS'(1); pins_d.addr = MR1; end
          default: begin pins_d.ba = BA_BITS'(0); pins_d.addr = MR0; end
        endcase
      end
      CMD_ZQCL: begin
        pins_d.we_n     = 1'b0;
        pins_d.addr[10] = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET_HOLD;
      cnt_q   <= LD_RESET;
      step_q  <= 2'd0;
      pins_q  <= PINS_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      pins_q  <= pins_d;
    end
  end

  assign mem_rst_n = pins_q.rst_n;
  assign mem_cke   = pins_q.cke;
  assign mem_cs_n  = {RANKS{pins_q.cs_n}};
  assign mem_ras_n = pins_q.ras_n;
  assign mem_cas_n = pins_q.cas_n;
  assign mem_we_n  = pins_q.we_n;
  assign mem_ba    = pins_q.ba;
  assign mem_addr  = pins_q.addr;
  assign mem_odt   = '0;
  assign init_done = pins_q.done;

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Self-checking bench for ddr3_init_seq. Two instances: one with the small
// nominal intervals, one with every interval at 1. Stimulus pushes the
// expected pin-bus changes (edge number + full pin snapshot) into a queue.
// A monitor samples on the falling edge. Whenever the observed bus changes,
// it pops the next expectation and compares it.
module tb_ddr3_init_seq;

  typedef struct packed {
    logic       rst_n;
    logic       cke;
    logic [1:0] cs_n;
    logic       ras_n;
    logic       cas_n;
    logic       we_n;
    logic [2:0] ba;
    logic [13:0] addr;
    logic [1:0] odt;
    logic       done;
  } bus_t;

  typedef enum {K_IDLE, K_RSTHI, K_NOP, K_MRS, K_ZQ, K_DONE} kind_e;

  typedef struct {
    int    cyc;
    bus_t  val;
    string name;
  } exp_t;

  localparam bus_t IDLE_B = '{rst_n: 1'b0, cke: 1'b0, cs_n: 2'b11, ras_n: 1'b1,
                              cas_n: 1'b1, we_n: 1'b1, ba: 3'd0, addr: 14'd0,
                              odt: 2'b00, done: 1'b0};

  // Hand-computed nominal schedule (T_RESET=10, T_CKE=20, T_XPR=5, T_MRD=4,
  // T_MOD=12, T_ZQINIT=32): edge offset, kind, ba, addr.
  localparam int          NOM_N = 13;
  localparam int          NOM_OFF [NOM_N] = '{10, 30, 35, 36, 39, 40, 43, 44, 47, 48, 59, 60, 91};
  localparam kind_e       NOM_K   [NOM_N] = '{K_RSTHI, K_NOP, K_MRS, K_NOP, K_MRS, K_NOP,
                                              K_MRS, K_NOP, K_MRS, K_NOP, K_ZQ, K_NOP, K_DONE};
  localparam logic [2:0]  NOM_BA  [NOM_N] = '{0, 0, 2, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0};
  localparam logic [13:0] NOM_A   [NOM_N] = '{14'h0, 14'h0, 14'h0008, 14'h0, 14'h0000, 14'h0,
                                              14'h0044, 14'h0, 14'h0520, 14'h0, 14'h0400,
                                              14'h0, 14'h0};

  // Every interval = 1: one change per edge, commands back to back.
  localparam int          MIN_N = 8;
  localparam int          MIN_OFF [MIN_N] = '{1, 2, 3, 4, 5, 6, 7, 8};
  localparam kind_e       MIN_K   [MIN_N] = '{K_RSTHI, K_NOP, K_MRS, K_MRS, K_MRS, K_MRS,
                                              K_ZQ, K_DONE};
  localparam logic [2:0]  MIN_BA  [MIN_N] = '{0, 0, 2, 3, 1, 0, 0, 0};
  localparam logic [13:0] MIN_A   [MIN_N] = '{14'h0, 14'h0, 14'h0008, 14'h0000, 14'h0044,
                                              14'h0520, 14'h0400, 14'h0};

  logic ck = 1'b0;
  logic rst_n_nom, rst_n_min, init_req;
  logic sel = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic        n_rst_n, n_cke, n_ras_n, n_cas_n, n_we_n, n_done;
  logic [1:0]  n_cs_n, n_odt;
  logic [2:0]  n_ba;
  logic [13:0] n_addr;
  logic        m_rst_n, m_cke, m_ras_n, m_cas_n, m_we_n, m_done;
  logic [1:0]  m_cs_n, m_odt;
  logic [2:0]  m_ba;
  logic [13:0] m_addr;
  bus_t        bus_nom, bus_min;

  ddr3_init_seq #(
    .ADDR_BITS(14), .BA_BITS(3), .RANKS(2),
    .T_RESET(10), .T_CKE(20), .T_XPR(5), .T_MRD(4), .T_MOD(12), .T_ZQINIT(32),
    .MR0(14'h0520), .MR1(14'h0044), .MR2(14'h0008), .MR3(14'h0000)
  ) dut_nom (
    .ck(ck), .rst_n(rst_n_nom), .init_req(init_req),
    .mem_rst_n(n_rst_n), .mem_cke(n_cke), .mem_cs_n(n_cs_n),
    .mem_ras_n(n_ras_n), .mem_cas_n(n_cas_n), .mem_we_n(n_we_n),
    .mem_ba(n_ba), .mem_addr(n_addr), .mem_odt(n_odt), .init_done(n_done)
  );

  ddr3_init_seq #(
    .ADDR_BITS(14), .BA_BITS(3), .RANKS(2),
    .T_RESET(1), .T_CKE(1), .T_XPR(1), .T_MRD(1), .T_MOD(1), .T_ZQINIT(1),
    .MR0(14'h0520), .MR1(14'h0044), .MR2(14'h0008), .MR3(14'h0000)
  ) dut_min (
    .ck(ck), .rst_n(rst_n_min), .init_req(1'b0),
    .mem_rst_n(m_rst_n), .mem_cke(m_cke), .mem_cs_n(m_cs_n),
    .mem_ras_n(m_ras_n), .mem_cas_n(m_cas_n), .mem_we_n(m_we_n),
    .mem_ba(m_ba), .mem_addr(m_addr), .mem_odt(m_odt), .init_done(m_done)
  );

  assign bus_nom = {n_rst_n, n_cke, n_cs_n, n_ras_n, n_cas_n, n_we_n, n_ba, n_addr, n_odt, n_done};
  assign bus_min = {m_rst_n, m_cke, m_cs_n, m_ras_n, m_cas_n, m_we_n, m_ba, m_addr, m_odt, m_done};

  initial forever #5 ck = ~ck;
  always @(posedge ck) cyc++;

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic bus_t mk(input kind_e k, input logic [2:0] ba, input logic [13:0] addr);
    bus_t b;
    b = IDLE_B;
    if (k != K_IDLE) b.rst_n = 1'b1;
    if (k inside {K_NOP, K_MRS, K_ZQ, K_DONE}) begin
      b.cke  = 1'b1;
      b.cs_n = 2'b00;
    end
    if (k == K_MRS) begin
      b.ras_n = 1'b0;
      b.cas_n = 1'b0;
      b.we_n  = 1'b0;
    end
    if (k == K_ZQ) b.we_n = 1'b0;
    if (k inside {K_MRS, K_ZQ}) begin
      b.ba   = ba;
      b.addr = addr;
    end
    if (k == K_DONE) b.done = 1'b1;
    return b;
  endfunction

  task automatic push(input int c, input kind_e k, input logic [2:0] ba,
                      input logic [13:0] addr, input string name);
    exp_t e;
    e.cyc  = c;
    e.val  = mk(k, ba, addr);
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic push_nominal(input int base, input int upto);
    for (int i = 0; i < NOM_N; i++)
      if (NOM_OFF[i] <= upto)
        push(base + NOM_OFF[i], NOM_K[i], NOM_BA[i], NOM_A[i],
             $sformatf("nom_%s_e%0d", NOM_K[i].name(), NOM_OFF[i]));
  endtask

  task automatic push_min(input int base);
    for (int i = 0; i < MIN_N; i++)
      push(base + MIN_OFF[i], MIN_K[i], MIN_BA[i], MIN_A[i],
           $sformatf("min_%s_e%0d", MIN_K[i].name(), MIN_OFF[i]));
  endtask

  // Returns on the falling edge after rising edge n (cyc==n).
  task automatic at_edge(input int n);
    while (cyc < n) @(negedge ck);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge ck);
      n++;
    end
    #1;
    check("drain", exp_q.size() == 0,
          $sformatf("%0d expected changes never seen within %0d cycles", exp_q.size(), budget));
    exp_q.delete();
  endtask

  // Asynchronous reset of the nominal instance between edges; the monitor
  // sees the reset values on the next falling edge.
  task automatic drop_nom();
    push(cyc + 1, K_IDLE, 3'd0, 14'd0, "async_drop");
    #1 rst_n_nom = 1'b0;
    #1 check("async_reset_values", bus_nom === IDLE_B,
             $sformatf("got bus=%h, want %h", bus_nom, IDLE_B));
  endtask

  bus_t prev = IDLE_B;

  always @(negedge ck) begin
    bus_t cur;
    exp_t e;
    cur = sel ? bus_min : bus_nom;
    if (cur !== prev) begin
      check("spurious_change", exp_q.size() != 0,
            $sformatf("cyc=%0d got bus=%h with no change expected", cyc, cur));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(e.name, (cur === e.val) && (cyc == e.cyc),
              $sformatf("got cyc=%0d bus=%h, want cyc=%0d bus=%h", cyc, cur, e.cyc, e.val));
      end
      prev = cur;
    end
  end

  initial begin
    int base;
    rst_n_nom = 1'b1;
    rst_n_min = 1'b1;
    init_req  = 1'b0;
    #1;
    rst_n_nom = 1'b0;
    rst_n_min = 1'b0;

    // Reset values on both instances.
    @(negedge ck);
    check("reset_nom", bus_nom === IDLE_B, $sformatf("got bus=%h, want %h", bus_nom, IDLE_B));
    check("reset_min", bus_min === IDLE_B, $sformatf("got bus=%h, want %h", bus_min, IDLE_B));
    at_edge(3);

    // Nominal bring-up, then a one-cycle re-init request at edge 100.
    rst_n_nom = 1'b1;
    base = cyc;
    push_nominal(base, 1000);
    push(base + 101, K_IDLE, 3'd0, 14'd0, "reinit_drop");
    push_nominal(base + 101, 1000);
    at_edge(base + 100);
    init_req = 1'b1;
    at_edge(base + 101);
    init_req = 1'b0;
    drain(200);

    // Mid-sequence reset at edge 41, between MR3 and MR1.
    drop_nom();
    at_edge(cyc + 3);
    rst_n_nom = 1'b1;
    base = cyc;
    push_nominal(base, 40);
    at_edge(base + 41);
    drop_nom();
    at_edge(cyc + 3);
    rst_n_nom = 1'b1;
    base = cyc;
    push_nominal(base, 1000);
    drain(150);

    // Request held from edge 5 to edge 60 is ignored outside DONE.
    drop_nom();
    at_edge(cyc + 3);
    rst_n_nom = 1'b1;
    base = cyc;
    push_nominal(base, 1000);
    at_edge(base + 5);
    init_req = 1'b1;
    at_edge(base + 60);
    init_req = 1'b0;
    at_edge(base + 100);
    drain(10);

    // Minimum intervals on the second instance.
    drop_nom();
    drain(10);
    sel = 1'b1;
    at_edge(cyc + 2);
    rst_n_min = 1'b1;
    base = cyc;
    push_min(base);
    drain(50);
    at_edge(cyc + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
